// File: rtl/pos_list_ctrl.sv
// pos_list_ctrl
// -------------
// Sits in front of the dual-port position RAM. Positions streamed in from the
// move generator are written through port A while the list is being filled.
// Once the list is closed they are read back through port B and presented in
// order on a valid/ready stream. A 2-entry skid FIFO hides the RAM's 1-cycle
// read latency, so the output runs at 1 position/cycle under backpressure.
//
// Optional feature macro: POS_LIST_REPLAY_EN
//   defined   : replay in DONE re-drains the completed list.
//   undefined : replay is ignored; DONE exits only via clear or reset.
//
// The list depth comes from the `MAX_POSITIONS macro (defaults to 8 here when
// the parent build does not define it).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   clear             pulse: discard list, start a new fill (highest priority)
//   close             pulse: end of list (FILL only)
//   replay            pulse: re-drain completed list (optional feature)
//   in_valid/in_ready/in_data              upstream position stream
//   out_valid/out_ready/out_data/out_index/out_last   downstream stream
//   done              one-cycle pulse when a drain completes or an empty list closes
//   count             number of entries stored (0..`MAX_POSITIONS)
//   overflow          sticky: a beat was dropped because the list was full
//   ram_a_*           RAM port A (write side)
//   ram_b_*           RAM port B (read side; write enable tied low)

`ifndef MAX_POSITIONS
`define MAX_POSITIONS 8
`endif

module pos_list_ctrl #(
  parameter int RAM_WIDTH          = 0,
  parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS),
  // The parent always overrides RAM_WIDTH; clamping keeps the default
  // elaboration legal instead of producing a [-1:0] bus.
  localparam int DW = (RAM_WIDTH > 0) ? RAM_WIDTH : 1,
  localparam int AW = MAX_POSITIONS_LOG2,
  localparam int CW = MAX_POSITIONS_LOG2 + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          close,
  input  logic          replay,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          ram_a_wr_en,
  output logic [AW-1:0] ram_a_addr,
  output logic [DW-1:0] ram_a_wr_data,
  output logic          ram_b_wr_en,
  output logic [AW-1:0] ram_b_addr,
  input  logic [DW-1:0] ram_b_rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] MAX_C = CW'(`MAX_POSITIONS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          done_q, done_d;

  // Read issued last cycle; its data is on ram_b_rd_data this cycle.
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_idx_q, inflight_idx_d;

  // Skid FIFO, entry 0 is the head and drives the output directly.
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic [AW-1:0] fifo_idx_q  [2];
  logic [AW-1:0] fifo_idx_d  [2];

  logic          beat;
  logic          list_full;
  logic          wr_fire;
  logic          pop;
  logic          issue;
  logic [1:0]    cnt_after_pop;
  logic [CW-1:0] count_after_beat;

  // ---------------------------------------------------------------------
  // Write path (combinational from in_valid/in_data)
  // ---------------------------------------------------------------------
  assign in_ready      = (state_q == S_FILL);
  // A beat coinciding with clear belongs to the discarded list.
  assign beat          = in_ready & in_valid & ~clear;
  assign list_full     = (count_q == MAX_C);
  assign wr_fire       = beat & ~list_full;

  assign ram_a_wr_en   = wr_fire;
  assign ram_a_addr    = count_q[AW-1:0];
  assign ram_a_wr_data = in_data;

  assign ram_b_wr_en   = 1'b0;
  assign ram_b_addr    = rd_ptr_q[AW-1:0];

  // ---------------------------------------------------------------------
  // Output stream from the FIFO head
  // ---------------------------------------------------------------------
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[0];
  assign out_index = fifo_idx_q[0];
  assign out_last  = out_valid & ({1'b0, fifo_idx_q[0]} == (count_q - ONE_C));
  assign pop       = out_valid & out_ready;

  assign done      = done_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Occupancy is taken after this cycle's pop so a read can be issued in the
  // same cycle an entry leaves; otherwise a bubble appears every other beat.
  assign cnt_after_pop = fifo_cnt_q - {1'b0, pop};
  assign issue = (state_q == S_DRAIN) & ~clear & (rd_ptr_q < count_q) &
                 ((cnt_after_pop + {1'b0, inflight_q}) < 2'd2);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    overflow_d       = overflow_q;
    rd_ptr_d         = rd_ptr_q;
    done_d           = 1'b0;
    count_after_beat = count_q + (wr_fire ? ONE_C : '0);
    count_d          = count_after_beat;

    if (beat && list_full) begin
      overflow_d = 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end

    case (state_q)
      S_IDLE: begin
      end
      S_FILL: begin
        // close sees the count including a beat in the same cycle.
        if (close) begin
          if (count_after_beat == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
`ifdef POS_LIST_REPLAY_EN
        if (replay) begin
          state_d  = S_DRAIN;
          rd_ptr_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d    = S_FILL;
      count_d    = '0;
      overflow_d = 1'b0;
      rd_ptr_d   = '0;
      done_d     = 1'b0;
    end
  end

`ifndef POS_LIST_REPLAY_EN
  logic unused_replay;
  assign unused_replay = replay;
`endif

  // ---------------------------------------------------------------------
  // Read pipeline and skid FIFO
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;

    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_idx_d[0]  = fifo_idx_q[1];
    end
    // The issue rule guarantees at most one entry remains after a pop
    // whenever a read is returning, so the push slot is 0 or 1.
    if (inflight_q) begin
      fifo_data_d[cnt_after_pop[0]] = ram_b_rd_data;
      fifo_idx_d[cnt_after_pop[0]]  = inflight_idx_q;
    end
    fifo_cnt_d     = cnt_after_pop + {1'b0, inflight_q};

    inflight_d     = issue;
    inflight_idx_d = rd_ptr_q[AW-1:0];

    // Flush queued entries and squash the read that is returning now.
    if (clear) begin
      fifo_cnt_d = 2'd0;
      inflight_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      rd_ptr_q       <= '0;
      done_q         <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      fifo_cnt_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      rd_ptr_q       <= rd_ptr_d;
      done_q         <= done_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      fifo_cnt_q     <= fifo_cnt_d;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_idx_q[i]  <= fifo_idx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pos_list_ctrl.sv
// tb_pos_list_ctrl
// ----------------
// Directed bench for pos_list_ctrl with a behavioural dual-port RAM
// (port A write, port B registered read). Inputs are driven on the falling
// edge and outputs sampled 1 time unit later, well away from the rising edge.
// Optional feature macro exercised: POS_LIST_REPLAY_EN.

`ifndef MAX_POSITIONS
`define MAX_POSITIONS 8
`endif

module tb_pos_list_ctrl;

  localparam int W    = 8;
  localparam int L    = $clog2(`MAX_POSITIONS);
  localparam int MAXP = `MAX_POSITIONS;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         clear     = 1'b0;
  logic         close     = 1'b0;
  logic         replay    = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         out_ready = 1'b1;

  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [L-1:0] out_index;
  logic         out_last;
  logic         done;
  logic [L:0]   count;
  logic         overflow;
  logic         ram_a_wr_en;
  logic [L-1:0] ram_a_addr;
  logic [W-1:0] ram_a_wr_data;
  logic         ram_b_wr_en;
  logic [L-1:0] ram_b_addr;
  logic [W-1:0] ram_b_rd_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_data [MAXP+8];

  always #5 clk = ~clk;

  pos_list_ctrl #(.RAM_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .close        (close),
    .replay       (replay),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .done         (done),
    .count        (count),
    .overflow     (overflow),
    .ram_a_wr_en  (ram_a_wr_en),
    .ram_a_addr   (ram_a_addr),
    .ram_a_wr_data(ram_a_wr_data),
    .ram_b_wr_en  (ram_b_wr_en),
    .ram_b_addr   (ram_b_addr),
    .ram_b_rd_data(ram_b_rd_data)
  );

  // Behavioural position RAM with 1-cycle registered read.
  logic [W-1:0] mem [MAXP];
  always @(posedge clk) begin
    if (ram_a_wr_en) mem[ram_a_addr] <= ram_a_wr_data;
    ram_b_rd_data <= mem[ram_b_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_list();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_close();
    close = 1'b1;
    step();
    close = 1'b0;
  endtask

  // clear, n beats of base+i, then close (optionally on the last beat).
  task automatic fill_list(input int n, input int base, input bit close_on_last);
    start_list();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = W'(base + i);
      close    = close_on_last && (i == n - 1);
      if (i < MAXP) exp_data[i] = (base + i) & 'hFF;
      step();
    end
    in_valid = 1'b0;
    close    = 1'b0;
    if (!close_on_last) do_close();
  endtask

  // Runs the drain until done, comparing every presented entry against the
  // bench's expected list. toggle=1 drives out_ready as 1,0,0,1 repeating.
  task automatic drain_check(input string tag, input int n, input bit toggle);
    int  k;
    bit  seen_done;
    k         = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 80 && !seen_done; c++) begin
      out_ready = toggle ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      #1;
      if (done) begin
        seen_done = 1'b1;
      end else if (out_valid) begin
        if (k < n) begin
          check({tag, " data"}, 32'(out_data), exp_data[k]);
          check({tag, " index"}, 32'(out_index), k);
          check({tag, " last"}, 32'(out_last), (k == n - 1) ? 1 : 0);
        end
        if (out_ready) k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    check({tag, " handshakes"}, k, n);
    check({tag, " done seen"}, 32'(seen_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int vcnt;
    int dcnt;

    // ---------------- reset state ----------------
    @(negedge clk);
    #1;
    check("rst count", 32'(count), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- t1: basic fill/drain with exact timing ----------------
    start_list();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hA0 + i);
      exp_data[i] = 32'hA0 + i;
      #1;
      check("t1 wr_en", 32'(ram_a_wr_en), 1);
      check("t1 wr_addr", 32'(ram_a_addr), i);
      step();
    end
    in_valid = 1'b0;
    check("t1 count", 32'(count), 5);
    check("t1 ram_b_wr_en", 32'(ram_b_wr_en), 0);
    do_close();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c < 2) begin
        check("t1 latency no valid", 32'(out_valid), 0);
      end else if (c < 7) begin
        check("t1 valid", 32'(out_valid), 1);
        check("t1 index", 32'(out_index), c - 2);
        check("t1 data", 32'(out_data), 32'hA0 + c - 2);
        check("t1 last", 32'(out_last), (c == 6) ? 1 : 0);
        check("t1 done low", 32'(done), 0);
      end else begin
        check("t1 done pulse", 32'(done), 1);
        check("t1 valid after", 32'(out_valid), 0);
      end
      @(negedge clk);
    end
    #1;
    check("t1 done one cycle", 32'(done), 0);
    @(negedge clk);

    // ---------------- t2: backpressure 1,0,0,1 ----------------
    fill_list(5, 'hA0, 1'b0);
    drain_check("t2 stall", 5, 1'b1);

    // ---------------- t6: replay after done ----------------
    replay = 1'b1;
    step();
    replay = 1'b0;
`ifdef POS_LIST_REPLAY_EN
    drain_check("t6 replay", 5, 1'b0);
`else
    vcnt = 0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) vcnt++;
      if (done) dcnt++;
      @(negedge clk);
    end
    check("t6 replay ignored valid", vcnt, 0);
    check("t6 replay ignored done", dcnt, 0);
`endif

    // ---------------- t3: overflow ----------------
    fill_list(MAXP + 3, 'hB0, 1'b0);
    check("t3 count", 32'(count), MAXP);
    check("t3 overflow", 32'(overflow), 1);
    drain_check("t3 drain", MAXP, 1'b0);

    // ---------------- t4a: empty list ----------------
    start_list();
    #1;
    check("t4a overflow cleared", 32'(overflow), 0);
    @(negedge clk);
    do_close();
    #1;
    check("t4a done", 32'(done), 1);
    check("t4a count", 32'(count), 0);
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) vcnt++;
      @(negedge clk);
    end
    check("t4a no valid", vcnt, 0);

    // ---------------- t4b: last beat with close ----------------
    fill_list(3, 'h75, 1'b1);
    check("t4b count", 32'(count), 3);
    drain_check("t4b drain", 3, 1'b0);

    // ---------------- t5: clear mid-drain ----------------
    fill_list(5, 'hA0, 1'b0);
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      #1;
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    check("t5 two drained", hs, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    check("t5 valid low", 32'(out_valid), 0);
    check("t5 count cleared", 32'(count), 0);
    @(negedge clk);
    // Beat coincident with clear in FILL is dropped.
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5 beat with clear dropped", 32'(count), 0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_valid = 1'b0;
    check("t5 count one", 32'(count), 1);
    exp_data[0] = 'h11;
    do_close();
    drain_check("t5 refill", 1, 1'b0);

    // ---------------- t5r: reset mid-drain ----------------
    fill_list(5, 'hA0, 1'b0);
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      #1;
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    check("t5r out_valid", 32'(out_valid), 0);
    check("t5r out_data", 32'(out_data), 0);
    check("t5r out_index", 32'(out_index), 0);
    check("t5r out_last", 32'(out_last), 0);
    check("t5r done", 32'(done), 0);
    check("t5r count", 32'(count), 0);
    check("t5r overflow", 32'(overflow), 0);
    check("t5r wr_en", 32'(ram_a_wr_en), 0);
    @(negedge clk);
    reset = 1'b0;
    // IDLE ignores beats and close.
    close = 1'b1;
    #1;
    check("t5r idle in_ready", 32'(in_ready), 0);
    check("t5r idle wr_en", 32'(ram_a_wr_en), 0);
    step();
    close    = 1'b0;
    in_valid = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) vcnt++;
      @(negedge clk);
    end
    check("t5r idle no valid", vcnt, 0);
    check("t5r idle count", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
